// File: rtl/bcd_result_converter_pkg.sv
// Shared definitions for the BCD result converter.
//  - state_t     : converter FSM states (IDLE -> CONV -> DONE -> IDLE)
//  - BCD_DIGIT_W : width of one packed BCD digit
package bcd_result_converter_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_result_converter_add3_cell.sv
// bcd_add3_cell: combinational double-dabble correction for one BCD digit.
//  Digits of 5 or more get +3 so that the following left shift carries
//  correctly into the next decimal digit. The result never exceeds 12,
//  so a plain 4-bit add without carry-out is sufficient.
// Ports:
//  digit      in   4  BCD digit before correction
//  corrected  out  4  digit after "if >= 5 add 3"
module bcd_add3_cell
    import bcd_result_converter_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] corrected
);

    // Conditional +3 correction.
    always_comb begin
        corrected = digit;
        if (digit >= 4'd5) begin
            corrected = digit + 4'd3;
        end else begin
            corrected = digit;
        end
    end

endmodule

// File: rtl/bcd_result_converter.sv
// bcd_result_converter: sequential binary-to-BCD converter (shift-add-3,
// one input bit per clock) for calculator results.
//  Accepts an unsigned IN_W-bit magnitude plus sign over valid/ready, runs
//  IN_W conversion cycles, then presents DIGITS packed BCD digits until the
//  downstream display driver takes them.
// Ports:
//  clk        in   1         system clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         in_data/in_neg valid
//  in_ready   out  1         converter idle and able to accept an operand
//  in_data    in   IN_W      unsigned binary magnitude
//  in_neg     in   1         sign flag, passed through unchanged
//  out_valid  out  1         out_bcd/out_neg hold a completed result
//  out_ready  in   1         downstream consumes result
//  out_bcd    out  4*DIGITS  packed BCD, digit 0 (ones) in [3:0]; 0 when not valid
//  out_neg    out  1         sign captured with in_data; 0 when not valid
module bcd_result_converter #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_data,
    input  logic                in_neg,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_neg
);

    import bcd_result_converter_pkg::*;

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + IN_W;
    localparam int CNT_W = $clog2(IN_W + 1);

    // The BCD field must be able to represent every IN_W-bit value.
    if ((10 ** DIGITS) <= (2 ** IN_W)) begin : g_param_check
        $error("bcd_result_converter: DIGITS too small for IN_W");
    end

    state_t             state_r;
    logic [SR_W-1:0]    sr_r;        // {bcd digits, remaining binary bits}
    logic [CNT_W-1:0]   cnt_r;
    logic               neg_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [BCD_W-1:0]   out_bcd_r;
    logic               out_neg_r;

    logic [BCD_W-1:0]   bcd_corr_s;
    logic [SR_W-1:0]    sr_next_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_cell u_add3 (
            .digit     (sr_r[IN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .corrected (bcd_corr_s[BCD_DIGIT_W*g +: BCD_DIGIT_W])
        );
    end

    // One conversion step: corrected digits, then shift the whole register left.
    assign sr_next_s = {bcd_corr_s, sr_r[IN_W-1:0]} << 1;

    // Converter FSM with all handshake and result outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            sr_r        <= {SR_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            neg_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_bcd_r   <= {BCD_W{1'b0}};
            out_neg_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_valid_r <= 1'b0;
                    out_bcd_r   <= {BCD_W{1'b0}};
                    out_neg_r   <= 1'b0;
                    if (in_valid && in_ready_r) begin
                        sr_r       <= {{BCD_W{1'b0}}, in_data};
                        neg_r      <= in_neg;
                        cnt_r      <= CNT_W'(IN_W);
                        in_ready_r <= 1'b0;
                        state_r    <= ST_CONV;
                    end else begin
                        // First IDLE cycle after reset release raises in_ready here.
                        in_ready_r <= 1'b1;
                    end
                end
                ST_CONV: begin
                    in_ready_r <= 1'b0;
                    sr_r       <= sr_next_s;
                    cnt_r      <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        // Last bit shifted in: capture the finished digits directly.
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        out_bcd_r   <= sr_next_s[SR_W-1 -: BCD_W];
                        out_neg_r   <= neg_r;
                    end else begin
                        state_r     <= ST_CONV;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        out_bcd_r   <= {BCD_W{1'b0}};
                        out_neg_r   <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_bcd_r   <= {BCD_W{1'b0}};
                    out_neg_r   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_bcd   = out_bcd_r;
    assign out_neg   = out_neg_r;

endmodule
